// File: rtl/led_breather.sv
// PWM "breathing" LED driver: ramps duty up, holds bright, ramps down, holds dark.
// Duty and phase only change on PWM period boundaries so the LED never glitches.
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                sysClk,
  input  logic                sysRstN,
  input  logic                en,
  input  logic                stepTick,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase
);

  localparam int HC_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] LAST_CNT = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] STEP_N   = PWM_BITS'(STEP);
  localparam logic [HC_W-1:0]     HOLD_LAST =
    HC_W'((HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  phase_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HC_W-1:0]     hold_q, hold_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                pend_q, pend_d;
  logic                led_q, led_d;
  logic                boundary;
  logic                accept;
  logic                hold_done;

  // Widen by one bit so duty+STEP cannot wrap before the clamp.
  function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + {1'b0, STEP_N};
    return (s > {1'b0, MAX}) ? MAX : s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
    return (d > STEP_N) ? (d - STEP_N) : '0;
  endfunction

  assign boundary  = (pwm_q == LAST_CNT);
  assign accept    = en & boundary & (pend_q | stepTick);
  assign hold_done = (HOLD_TICKS == 0) || (hold_q >= HOLD_LAST);

  assign pwm_d = boundary ? '0 : pwm_q + 1'b1;

  // A tick on the boundary cycle is consumed there, so boundary clears before set.
  always_comb begin
    pend_d = pend_q;
    if (!en)           pend_d = 1'b0;
    else if (boundary) pend_d = 1'b0;
    else if (stepTick) pend_d = 1'b1;
  end

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      pwm_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q <= RISE;
      duty_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    if (accept) begin
      case (state_q)
        RISE: begin
          duty_d = sat_inc(duty_q);
          if (duty_d == MAX) begin
            state_d = HOLD_HI;
            hold_d  = '0;
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            state_d = FALL;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        FALL: begin
          duty_d = sat_dec(duty_q);
          if (duty_d == '0) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            state_d = RISE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = RISE;
      endcase
    end
  end

  always_comb begin
    led_d = en & (pwm_q < duty_q);
  end

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) led_q <= 1'b0;
    else          led_q <= led_d;
  end

  assign led   = led_q;
  assign duty  = duty_q;
  assign phase = state_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: expected duty/phase changes are queued per step
// and a monitor pops them whenever a DUT's visible state changes.
module tb_led_breather;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       tick5 = 1'b0;
  logic       tick4 = 1'b0;
  logic       led5, led4;
  logic [3:0] duty5, duty4;
  logic [1:0] phase5, phase4;

  int total = 0;
  int bad = 0;
  int cnt_m = 0;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] p;
  } ev_t;

  ev_t q5[$];
  ev_t q4[$];
  ev_t prev5, prev4;

  led_breather #(.PWM_BITS(4), .STEP(5), .HOLD_TICKS(2)) dut5 (
    .sysClk(clk), .sysRstN(rst_n), .en(en), .stepTick(tick5),
    .led(led5), .duty(duty5), .phase(phase5)
  );

  led_breather #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(2)) dut4 (
    .sysClk(clk), .sysRstN(rst_n), .en(en), .stepTick(tick4),
    .led(led4), .duty(duty4), .phase(phase4)
  );

  always #5 clk = ~clk;

  // Reference PWM position: value the DUT counter holds after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_m <= 0;
    else        cnt_m <= (cnt_m == 14) ? 0 : cnt_m + 1;
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    ev_t cur, e;
    cur = {duty5, phase5};
    if (!rst_n) begin
      prev5 = cur;
    end else if (cur != prev5) begin
      if (q5.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut5_unexpected: got duty=%0d phase=%0d, expected no change from duty=%0d phase=%0d",
                 duty5, phase5, prev5.d, prev5.p);
      end else begin
        e = q5.pop_front();
        chk("dut5_duty", int'(duty5), int'(e.d));
        chk("dut5_phase", int'(phase5), int'(e.p));
      end
      prev5 = cur;
    end
  end

  always @(negedge clk) begin
    ev_t cur, e;
    cur = {duty4, phase4};
    if (!rst_n) begin
      prev4 = cur;
    end else if (cur != prev4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut4_unexpected: got duty=%0d phase=%0d, expected no change from duty=%0d phase=%0d",
                 duty4, phase4, prev4.d, prev4.p);
      end else begin
        e = q4.pop_front();
        chk("dut4_duty", int'(duty4), int'(e.d));
        chk("dut4_phase", int'(phase4), int'(e.p));
      end
      prev4 = cur;
    end
  end

  task automatic push5(input int d, input int p);
    q5.push_back({4'(d), 2'(p)});
  endtask

  task automatic push4(input int d, input int p);
    q4.push_back({4'(d), 2'(p)});
  endtask

  // One tick, then a full period so exactly one boundary consumes it.
  task automatic step(input int which);
    @(negedge clk);
    if (which == 5) tick5 = 1'b1;
    else            tick4 = 1'b1;
    @(negedge clk);
    tick5 = 1'b0;
    tick4 = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic pulse5();
    tick5 = 1'b1;
    @(negedge clk);
    tick5 = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 20 && cnt_m != v; i++) @(negedge clk);
  endtask

  task automatic led_window(input int which, input int req, input string nm);
    int n;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      n += (which == 5) ? int'(led5) : int'(led4);
    end
    chk(nm, n, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_led", int'(led5), 0);
      chk("idle_duty", int'(duty5), 0);
      chk("idle_phase", int'(phase5), 0);
    end

    // Saturating ramp with STEP=4.
    push4(4, 0);  step(4);
    push4(8, 0);  step(4);
    push4(12, 0); step(4);
    push4(15, 1); step(4);
    step(4);
    push4(15, 2); step(4);
    push4(11, 2); step(4);
    push4(7, 2);  step(4);
    push4(3, 2);  step(4);
    push4(0, 3);  step(4);
    chk("dut4_final_phase", int'(phase4), 3);

    // Full breathing cycle with STEP=5.
    push5(5, 0);  step(5);
    led_window(5, 5, "led_duty5_ones");
    push5(10, 0); step(5);
    led_window(5, 10, "led_duty10_ones");
    push5(15, 1); step(5);
    led_window(5, 15, "led_full_on");
    step(5);
    push5(15, 2); step(5);
    push5(10, 2); step(5);
    push5(5, 2);  step(5);
    push5(0, 3);  step(5);
    led_window(5, 0, "led_full_off");
    step(5);
    push5(0, 0);  step(5);

    // Several ticks in one period, then one tick on a boundary cycle.
    push5(5, 0);
    push5(10, 0);
    wait_cnt(2); pulse5();
    wait_cnt(5); pulse5();
    wait_cnt(8); pulse5();
    wait_cnt(0);
    @(negedge clk);
    chk("multi_tick_duty", int'(duty5), 5);
    wait_cnt(14); pulse5();
    repeat (35) @(negedge clk);
    chk("boundary_tick_duty", int'(duty5), 10);

    // Disable at duty=10 while the LED is lit.
    wait_cnt(2);
    chk("pre_disable_led", int'(led5), 1);
    en = 1'b0;
    @(negedge clk);
    chk("disable_led", int'(led5), 0);
    begin
      int ones;
      ones = 0;
      for (int i = 0; i < 45; i++) begin
        tick5 = (i % 7 == 3);
        @(negedge clk);
        ones += int'(led5);
      end
      tick5 = 1'b0;
      chk("disabled_led_ones", ones, 0);
    end
    chk("disabled_duty", int'(duty5), 10);
    chk("disabled_phase", int'(phase5), 0);

    en = 1'b1;
    push5(15, 1); step(5);
    step(5);
    push5(15, 2); step(5);
    push5(10, 2); step(5);

    // Asynchronous reset mid-FALL while the LED is lit.
    wait_cnt(2);
    chk("pre_reset_led", int'(led5), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_led", int'(led5), 0);
    chk("reset_duty", int'(duty5), 0);
    chk("reset_phase", int'(phase5), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_duty", int'(duty5), 0);

    chk("q5_drained", q5.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
